// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch and data ports
// with data priority, anti-starvation for fetch and a memory timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err_timeout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, next_state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic in_busy, grant_i, grant_d, timed_out, finish;
  always_comb begin
    in_busy    = state == BUSY_I || state == BUSY_D;
    grant_i    = state == IDLE && i_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
    grant_d    = state == IDLE && d_req && !grant_i;
    timed_out  = wait_cnt == WW'(TIMEOUT - 1);
    finish     = in_busy && (m_ready || timed_out);
    next_state = grant_i ? BUSY_I : grant_d ? BUSY_D : finish ? RESP : state == RESP ? IDLE : state;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= in_busy ? wait_cnt + 1'b1 : '0;
      if (grant_i || grant_d) begin
        m_req   <= 1'b1;
        m_we    <= grant_d && d_we;
        m_addr  <= grant_d ? d_addr : i_addr;
        m_wdata <= grant_d ? d_wdata : '0;
      end
      if (grant_i) starve_cnt <= '0;
      else if (grant_d && i_req && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      // m_ready on the timeout edge still completes the transaction normally
      if (finish) begin
        m_req       <= 1'b0;
        err_timeout <= !m_ready;
        if (state == BUSY_I) begin
          i_done  <= 1'b1;
          i_rdata <= m_ready ? m_rdata : '0;
        end else begin
          d_done <= 1'b1;
          if (!m_ready) d_rdata <= '0;
          else if (!m_we) d_rdata <= m_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard and a checking
// memory model; expectations are queued up front and popped as the DUT answers.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 0;
  logic        i_req = 0, d_req = 0, d_we = 0, m_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_req, m_we, err_timeout, busy;
  int vectors = 0, miscompares = 0;
  int lat = 0, i_left = 0, d_left = 0, mcyc = 0;
  typedef struct {bit port; logic [31:0] rdata; bit err; int mc;} resp_t;
  typedef struct {bit we; logic [31:0] addr, wdata, rdata;} mem_t;
  resp_t sb[$];
  mem_t mq[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_done(i_done), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .err_timeout(err_timeout),
    .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_resp(input bit port, input logic [31:0] rdata, input bit err, input int mc);
    resp_t r;
    r.port = port; r.rdata = rdata; r.err = err; r.mc = mc;
    sb.push_back(r);
  endtask

  task automatic push_mem(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata;
    mq.push_back(m);
  endtask

  // holds each request until its remaining transaction count is consumed
  task automatic run(input int budget);
    int c = 0;
    while ((i_left > 0 || d_left > 0) && c < budget) begin
      @(negedge clk);
      c++;
      if (i_done && i_left > 0) begin i_left--; if (i_left == 0) i_req = 0; end
      if (d_done && d_left > 0) begin d_left--; if (d_left == 0) d_req = 0; end
    end
    if (i_left > 0 || d_left > 0) begin
      vectors++; miscompares++;
      $display("FAIL run_budget: %0d fetch and %0d data transactions still pending", i_left, d_left);
      i_req = 0; d_req = 0; i_left = 0; d_left = 0;
    end
    @(negedge clk);
  endtask

  // memory model: checks each new request and answers after lat cycles (lat<0: never)
  initial begin
    int cnt = 0;
    mem_t cur;
    forever begin
      @(negedge clk);
      if (reset && m_req && !m_ready) begin
        if (cnt == 0) begin
          if (mq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_m_req: addr 0x%08h with no request expected", m_addr);
            cur.rdata = 0;
          end else begin
            cur = mq.pop_front();
            chk("m_we", {31'b0, m_we}, {31'b0, cur.we});
            chk("m_addr", m_addr, cur.addr);
            if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
          end
        end
        cnt++;
        if (lat >= 0 && cnt > lat) begin m_ready = 1; m_rdata = cur.rdata; end
      end else begin
        m_ready = 0; cnt = 0;
      end
    end
  end

  // response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset) mcyc = 0;
      else begin
        if (m_req) mcyc++;
        if (i_done && d_done) begin
          vectors++; miscompares++;
          $display("FAIL both_done: i_done=1 d_done=1 required not both");
        end
        if (i_done || d_done) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: i_done=%0b d_done=%0b with nothing expected", i_done, d_done);
          end else begin
            e = sb.pop_front();
            chk("done_port", {31'b0, d_done}, {31'b0, e.port});
            chk("rdata", d_done ? d_rdata : i_rdata, e.rdata);
            chk("err_timeout", {31'b0, err_timeout}, {31'b0, e.err});
            chk("mreq_cycles", mcyc, e.mc);
          end
          mcyc = 0;
        end else if (err_timeout) begin
          vectors++; miscompares++;
          $display("FAIL stray_err: err_timeout=1 without done");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // 1: reset
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_m_req", {31'b0, m_req}, 0);
    chk("rst_m_we", {31'b0, m_we}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_dones", {30'b0, i_done, d_done}, 0);
    chk("rst_err", {31'b0, err_timeout}, 0);
    // 2: single fetch, ready 2 cycles after m_req
    lat = 2;
    push_mem(0, 32'h40, 0, 32'h2008000A);
    push_resp(0, 32'h2008000A, 0, 3);
    i_addr = 32'h40; i_req = 1; i_left = 1;
    run(30);
    // 3: store and fetch together; store first, d_rdata untouched by a store
    lat = 1;
    push_mem(1, 32'h100, 32'hDEADBEEF, 32'hBAD0BAD0);
    push_mem(0, 32'h44, 0, 32'h12345678);
    push_resp(1, 32'h0, 0, 2);
    push_resp(0, 32'h12345678, 0, 2);
    d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; i_addr = 32'h44;
    d_req = 1; i_req = 1; d_left = 1; i_left = 1;
    run(40);
    // 4: back-to-back loads starve fetch; fetch forced after 4 data grants
    lat = 0;
    d_we = 0; d_addr = 32'h200; i_addr = 32'h80;
    push_mem(0, 32'h200, 0, 32'h11); push_resp(1, 32'h11, 0, 1);
    push_mem(0, 32'h200, 0, 32'h22); push_resp(1, 32'h22, 0, 1);
    push_mem(0, 32'h200, 0, 32'h33); push_resp(1, 32'h33, 0, 1);
    push_mem(0, 32'h200, 0, 32'h44); push_resp(1, 32'h44, 0, 1);
    push_mem(0, 32'h80, 0, 32'h55);  push_resp(0, 32'h55, 0, 1);
    push_mem(0, 32'h200, 0, 32'h66); push_resp(1, 32'h66, 0, 1);
    d_req = 1; i_req = 1; d_left = 5; i_left = 1;
    run(80);
    // 5: memory never answers -> timeout on 15th busy cycle, then normal fetch
    lat = -1;
    d_addr = 32'h300;
    push_mem(0, 32'h300, 0, 0);
    push_resp(1, 32'h0, 1, 15);
    d_req = 1; d_left = 1;
    run(60);
    lat = 1;
    push_mem(0, 32'h84, 0, 32'hCAFEF00D);
    push_resp(0, 32'hCAFEF00D, 0, 2);
    i_addr = 32'h84; i_req = 1; i_left = 1;
    run(30);
    // 6: reset mid-transaction kills it without a done
    lat = -1;
    d_addr = 32'h400;
    push_mem(0, 32'h400, 0, 0);
    d_req = 1;
    c = 0;
    while (!m_req && c < 10) begin @(negedge clk); c++; end
    chk("t6_m_req_seen", {31'b0, m_req}, 1);
    repeat (3) @(negedge clk);
    reset = 0; d_req = 0;
    @(negedge clk);
    chk("t6_m_req_drop", {31'b0, m_req}, 0);
    chk("t6_busy", {31'b0, busy}, 0);
    chk("t6_d_done", {31'b0, d_done}, 0);
    chk("t6_i_rdata", i_rdata, 0);
    reset = 1;
    repeat (20) @(negedge clk);
    chk("t6_idle_busy", {31'b0, busy}, 0);
    chk("sb_left", sb.size(), 0);
    chk("mq_left", mq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
